// File: rtl/flippy_pkg.sv
// ============================================================================
// flippy_pkg : shared constants, scheduler state encoding, level->period map
// Revision   : 1.0
// ============================================================================
`default_nettype none

package flippy_pkg;

    localparam int NUM_COLS = 3;
    localparam int LEVEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } sched_state_e;

    // Widened product so that a large level*step cannot wrap below the floor.
    function automatic logic [31:0] level_to_period(
        input logic [LEVEL_W-1:0] lvl,
        input logic [31:0]        base,
        input logic [31:0]        step,
        input logic [31:0]        floor_p
    );
        logic [35:0] red;
        logic [31:0] diff;
        logic [31:0] res;
        red  = 36'(lvl) * 36'(step);
        diff = base - red[31:0];
        res  = diff;
        if ((red >= 36'(base)) || (diff < floor_p)) begin
            res = floor_p;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/drop_scheduler_if.sv
// ============================================================================
// drop_scheduler_if : game-control and column-timing signals of the scheduler
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface drop_scheduler_if #(
    parameter int NUM_COLS = flippy_pkg::NUM_COLS
);
    import flippy_pkg::*;

    logic                start;
    logic [7:0]          score;
    logic [NUM_COLS-1:0] correct;
    logic [NUM_COLS-1:0] game_over;
    logic [NUM_COLS-1:0] spawn;
    logic [NUM_COLS-1:0] step;
    logic [NUM_COLS-1:0] active;
    logic [LEVEL_W-1:0]  level;
    logic                playing;
    logic                over;

    modport master (
        output start, score, correct, game_over,
        input  spawn, step, active, level, playing, over
    );

    modport slave (
        input  start, score, correct, game_over,
        output spawn, step, active, level, playing, over
    );

endinterface

`default_nettype wire

// File: rtl/tick_divider.sv
// ============================================================================
// tick_divider : loadable down-counter, one-cycle tick at terminal count
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tick_divider (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        clear,
    input  wire logic        en,
    input  wire logic [31:0] period,
    output logic             tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick = en && (cnt_q == 32'd0);

    // A load of period-1 places the next tick exactly period cycles later.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = period - 32'd1;
        end else if (en) begin
            cnt_d = tick ? (period - 32'd1) : (cnt_q - 32'd1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/drop_scheduler.sv
// ============================================================================
// drop_scheduler : central spawn/step sequencer for the falling-letter columns
//                  (speed ramp enabled by DROP_SCHED_SPEEDUP_EN)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module drop_scheduler #(
    parameter int          NUM_COLS      = flippy_pkg::NUM_COLS,
    parameter logic [31:0] BASE_PERIOD   = 32'd25_000_000,
    parameter logic [31:0] PERIOD_STEP   = 32'd1_500_000,
    parameter logic [31:0] MIN_PERIOD    = 32'd5_000_000,
    parameter int          STAGGER_STEPS = 4
) (
    input wire logic        clock,
    input wire logic        reset_n,
    drop_scheduler_if.slave bus
);
    import flippy_pkg::*;

    localparam int                  SW       = $clog2(STAGGER_STEPS + 1);
    localparam logic [NUM_COLS-1:0] COL0     = {{(NUM_COLS-1){1'b0}}, 1'b1};
    localparam logic [NUM_COLS-1:0] ALL_COLS = {NUM_COLS{1'b1}};

    sched_state_e        state_q, state_d;
    logic [NUM_COLS-1:0] active_q, active_d;
    logic [NUM_COLS-1:0] spawn_q, spawn_d;
    logic [NUM_COLS-1:0] step_q, step_d;
    logic [SW-1:0]       stagger_q, stagger_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                playing_q, playing_d;
    logic                over_q, over_d;

    logic                div_clear;
    logic                tick;
    logic [31:0]         period;
    logic [NUM_COLS-1:0] hit;
    logic [NUM_COLS-1:0] lowest_free;

`ifdef DROP_SCHED_SPEEDUP_EN
    assign level_d = bus.score[7] ? 4'd15 : bus.score[6:3];
    assign period  = level_to_period(level_q, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
`else
    logic        unused_score;
    logic [31:0] unused_params;
    assign unused_score  = ^bus.score;
    assign unused_params = PERIOD_STEP ^ MIN_PERIOD;
    assign level_d       = '0;
    assign period        = BASE_PERIOD;
`endif

    assign hit         = bus.correct & active_q;
    assign lowest_free = ~active_q & (active_q + COL0);

    tick_divider u_div (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (div_clear),
        .en      (state_q == ST_RUN),
        .period  (period),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        spawn_d   = '0;
        step_d    = '0;
        stagger_d = stagger_q;
        div_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    active_d  = COL0;
                    spawn_d   = COL0;
                    stagger_d = '0;
                    div_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if ((bus.game_over & active_q) != '0) begin
                    state_d   = ST_OVER;
                    active_d  = '0;
                    stagger_d = '0;
                end else begin
                    // A freshly matched column restarts at row 0, so it skips this step.
                    spawn_d = hit;
                    if (tick) begin
                        step_d = active_q & ~hit;
                        if (active_q != ALL_COLS) begin
                            if (stagger_q == SW'(STAGGER_STEPS - 1)) begin
                                spawn_d   = spawn_d | lowest_free;
                                active_d  = active_q | lowest_free;
                                stagger_d = '0;
                            end else begin
                                stagger_d = stagger_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = '0;
            end
        endcase
        playing_d = (state_d == ST_RUN);
        over_d    = (state_d == ST_OVER);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            spawn_q   <= '0;
            step_q    <= '0;
            stagger_q <= '0;
            level_q   <= '0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            spawn_q   <= spawn_d;
            step_q    <= step_d;
            stagger_q <= stagger_d;
            level_q   <= level_d;
            playing_q <= playing_d;
            over_q    <= over_d;
        end
    end

    assign bus.spawn   = spawn_q;
    assign bus.step    = step_q;
    assign bus.active  = active_q;
    assign bus.level   = level_q;
    assign bus.playing = playing_q;
    assign bus.over    = over_q;

endmodule

`default_nettype wire

// File: tb/tb_drop_scheduler.sv
// ============================================================================
// tb_drop_scheduler : randomized scoreboard bench for drop_scheduler
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_drop_scheduler;

    localparam int NC    = 3;
    localparam int BASE  = 10;
    localparam int PSTEP = 1;
    localparam int MINP  = 5;
    localparam int STAG  = 2;
`ifdef DROP_SCHED_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    drop_scheduler_if #(.NUM_COLS(NC)) bus ();

    drop_scheduler #(
        .NUM_COLS      (NC),
        .BASE_PERIOD   (32'(BASE)),
        .PERIOD_STEP   (32'(PSTEP)),
        .MIN_PERIOD    (32'(MINP)),
        .STAGGER_STEPS (STAG)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic [NC-1:0] spawn;
        logic [NC-1:0] step;
        logic [NC-1:0] active;
        logic [3:0]    level;
        logic          playing;
        logic          over;
    } out_t;

    out_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    // Reference model: game mode, live columns, absolute cycle of the next tick.
    int            m_mode;   // 0 idle, 1 run, 2 over
    logic [NC-1:0] m_act;
    int            m_now;
    int            m_tick_at;
    int            m_stag;
    int            m_level;

    function automatic out_t dut_out();
        out_t o;
        o.spawn   = bus.spawn;
        o.step    = bus.step;
        o.active  = bus.active;
        o.level   = bus.level;
        o.playing = bus.playing;
        o.over    = bus.over;
        return o;
    endfunction

    function automatic int period_of(input int lvl);
        int p;
        p = BASE - lvl * PSTEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_act = '0; m_now = 0; m_tick_at = 0; m_stag = 0; m_level = 0;
    endtask

    task automatic model_step(input bit st, input logic [7:0] sc,
                              input logic [NC-1:0] co, input logic [NC-1:0] go);
        out_t          e;
        logic [NC-1:0] matched;
        int            lvl_next;
        bit            placed;
        e = '0;
        lvl_next = SPEEDUP ? (((sc >> 3) > 15) ? 15 : int'(sc >> 3)) : 0;
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_act = 1; e.spawn = 1; m_stag = 0;
                m_tick_at = m_now + period_of(m_level);
            end
        end else if ((go & m_act) != 0) begin
            m_mode = 2; m_act = '0;
        end else begin
            matched = co & m_act;
            e.spawn = matched;
            if (m_now == m_tick_at) begin
                m_tick_at = m_now + period_of(m_level);
                e.step = m_act & ~matched;
                if (m_act != {NC{1'b1}}) begin
                    m_stag++;
                    if (m_stag == STAG) begin
                        m_stag = 0;
                        placed = 1'b0;
                        for (int i = 0; i < NC; i++) begin
                            if (!placed && !m_act[i]) begin
                                m_act[i] = 1'b1; e.spawn[i] = 1'b1; placed = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        e.active  = m_act;
        e.playing = (m_mode == 1);
        e.over    = (m_mode == 2);
        e.level   = 4'(lvl_next);
        m_level   = lvl_next;
        m_now++;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit st, input logic [7:0] sc,
                         input logic [NC-1:0] co, input logic [NC-1:0] go);
        @(negedge clock);
        bus.start = st; bus.score = sc; bus.correct = co; bus.game_over = go;
        model_step(st, sc, co, go);
        mon_en = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        out_t a;
        a = dut_out();
        n_cmp++;
        if (a !== out_t'(0)) begin
            n_bad++;
            $display("FAIL %s: got %h required 0", name, a);
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge clock);
        mon_en = 1'b0;
        exp_q.delete();
        bus.start = 1'b0; bus.score = '0; bus.correct = '0; bus.game_over = '0;
        #3 reset_n = 1'b0;
        #1 check_quiet({name, "_async"});
        @(posedge clock); #2 check_quiet({name, "_held"});
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        out_t a, e;
        forever begin
            @(posedge clock);
            #2;
            if (mon_en) begin
                a = dut_out();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL no_expectation: got %h", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL outputs t=%0t: got spawn=%b step=%b active=%b level=%0d playing=%b over=%b; required spawn=%b step=%b active=%b level=%0d playing=%b over=%b",
                                 $time, a.spawn, a.step, a.active, a.level, a.playing, a.over,
                                 e.spawn, e.step, e.active, e.level, e.playing, e.over);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit done;
        bus.start = 1'b0; bus.score = '0; bus.correct = '0; bus.game_over = '0;
        model_reset();
        #25 check_quiet("reset_initial");
        @(negedge clock);
        reset_n = 1'b1;

        // Idle: nothing but start should wake the scheduler.
        for (int i = 0; i < 20; i++)
            drive(1'b0, 8'($urandom), 3'($urandom), 3'($urandom));

        // Start and watch the staggered spawns fill all columns.
        drive(1'b1, 8'd0, '0, '0);
        for (int i = 0; i < 60; i++) drive(1'b0, 8'd0, '0, '0);

        // correct[1] landing on a tick cycle.
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (m_now == m_tick_at) begin
                drive(1'b0, 8'd0, 3'b010, '0);
                done = 1'b1;
            end else begin
                drive(1'b0, 8'd0, '0, '0);
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL tick_align: got no tick in 30 cycles required tick");
        end

        // Random play without game over, stray starts and shifting score.
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 15) == 0), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000, '0);

        // correct and game_over on the same column together.
        drive(1'b0, 8'd0, 3'b001, 3'b001);
        for (int i = 0; i < 15; i++)
            drive(1'b0, 8'($urandom), 3'($urandom), 3'($urandom));
        drive(1'b1, 8'd0, '0, '0);

        // Random play including game overs and restarts.
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 9) == 0), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                  ($urandom_range(0, 39) == 0) ? 3'($urandom) : 3'b000);

        // Asynchronous reset in the middle of a period.
        drive(1'b1, 8'd0, '0, '0);
        for (int i = 0; i < 6; i++) drive(1'b0, 8'd0, '0, '0);
        apply_reset("reset_midrun");
        for (int i = 0; i < 5; i++) drive(1'b0, 8'd0, '0, '0);

        // Top score: level saturates and the period hits its floor.
        drive(1'b0, 8'd200, '0, '0);
        drive(1'b1, 8'd200, '0, '0);
        for (int i = 0; i < 60; i++) drive(1'b0, 8'd200, '0, '0);

        @(negedge clock);
        mon_en = 1'b0;
        @(posedge clock); #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/drop_scheduler.md
# drop_scheduler

Sequences the three falling-letter columns of the game. It decides when each column spawns a new letter and when every active column advances one row. It also ramps the fall speed with the score and freezes play on game over. It sits between the score/top-level logic and the three column instances, replacing the free-running column timing with one central scheduler.

## Interface
Parameters:
- NUM_COLS, 3, number of columns scheduled
- BASE_PERIOD, 25_000_000, clock cycles per row step at level 0
- PERIOD_STEP, 1_500_000, cycles removed per speed level
- MIN_PERIOD, 5_000_000, floor on step period
- STAGGER_STEPS, 4, row steps between successive initial column spawns

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start request (debounced button)
- score  in  8  current score, unsigned
- correct  in  NUM_COLS  per-column pulse: letter matched by user
- game_over  in  NUM_COLS  per-column level: letter reached bottom row
- spawn  out  NUM_COLS  single-cycle pulse: column loads new letter, ypos=0
- step  out  NUM_COLS  single-cycle pulse: column advances one row
- active  out  NUM_COLS  column currently in play
- level  out  4  current speed level
- playing  out  1  high in RUN
- over  out  1  high in OVER

## Operation
- States:
  - IDLE (after reset): no spawn or step pulses.
  - RUN: normal play.
  - OVER: play frozen.
- IDLE or OVER, start=1 → RUN:
  - next cycle: spawn[0]=1, active=3'b001.
  - step counter, period counter and stagger counter are cleared.
- RUN, period tick:
  - step[i]=1 for every active column i.
  - The stagger counter increments on each tick.
- RUN, initial staggering: when the stagger counter reaches STAGGER_STEPS:
  - the lowest inactive column gets spawn=1 and its active bit is set;
  - the stagger counter clears.
  - Staggering stops once all columns are active.
- RUN, correct[i]=1 with active[i]=1:
  - spawn[i]=1 next cycle; the column stays active.
  - correct on an inactive column is ignored.
- RUN, game_over[i]=1 with active[i]=1:
  - → OVER next cycle; active cleared to 0.
  - All step/spawn pulses suppressed from that cycle on.
- OVER: outputs held quiet; only start leaves.
- Period:
  - period = max(BASE_PERIOD − level·PERIOD_STEP, MIN_PERIOD), computed in 32-bit unsigned; no underflow allowed.
  - level = min(score >> 3, 15).
- Boundary rules:
  - correct[i] and game_over[i] in the same cycle: game_over wins; no spawn.
  - correct[i] and period tick in the same cycle: spawn[i]=1, step[i]=0 that cycle (new letter starts at row 0).
  - Multiple correct bits in the same cycle: all corresponding spawns issue together.
  - start during RUN: ignored.
  - Level change mid-period: the new period applies from the next period reload, not the current count.

## Timing
- Reset values:
  - state=IDLE, spawn=0, step=0, active=0, level=0, playing=0, over=0;
  - all counters 0.
- All outputs are registered.
- Latency:
  - start → first spawn: 1 cycle.
  - correct → spawn: 1 cycle.
  - game_over → over=1: 1 cycle.
- Tick spacing:
  - first tick occurs `period` cycles after entry to RUN;
  - ticks are then exactly `period` cycles apart at constant level.
- spawn and step are never high for longer than one cycle.
- reset_n asserted mid-operation: immediate return to reset values, regardless of clock.

## Configuration
- DROP_SCHED_SPEEDUP_EN defined: level is derived from score as above; period shrinks with level.
- DROP_SCHED_SPEEDUP_EN undefined: the score input is unused, level is tied to 0, and period = BASE_PERIOD always.

## Structure
- Shared package flippy_pkg holds:
  - NUM_COLS;
  - the scheduler state enum (IDLE, RUN, OVER);
  - LEVEL_W=4 and the level-to-period function.
- One sub-module, tick_divider:
  - loadable down-counter producing the period tick;
  - reloads from the period input on terminal count;
  - cleared by a sync clear.

## Test plan
- Reset, then start pulse → spawn=3'b001 one cycle later, playing=1, active=3'b001.
- Test parameters BASE_PERIOD=10, STAGGER_STEPS=2, score=0 → step pulses every 10 cycles; spawn[1] on the 2nd tick and spawn[2] on the 4th; active ends at 3'b111.
- correct=3'b010 coincident with a tick → spawn=3'b010 and step=3'b101 in the same cycle.
- correct[0] and game_over[0] in the same cycle → no spawn; over=1 and active=0 next cycle; no further steps; a start then restarts with spawn[0].
- DROP_SCHED_SPEEDUP_EN defined, score=200 → level=15, period=max(25e6−22.5e6, 5e6)=5_000_000.
- DROP_SCHED_SPEEDUP_EN undefined, score=200 → level=0, period stays BASE_PERIOD.
- reset_n low during RUN mid-period → all outputs 0 asynchronously; state IDLE after release.
